score_uart_report: RTL and testbench

- Downstream consumer of the platform top's scoreboard counters (total, correct).
- On request or periodic tick, snapshots both 32-bit counters and transmits them to the host PC as a fixed 10-byte UART frame.
- Sits at the top level beside the scoreboard; drives the board UART TX pin.

---
 rtl/score_uart_report.sv | 212 +++++++++++++++++++++
 tb/tb_score_uart_report.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/score_uart_report.sv
// Snapshots the scoreboard counters on request or periodic tick and sends them
// to the host as a 10-byte 8N1 UART frame: A5, total (MSB first), correct (MSB first), XOR checksum.
module score_uart_report #(
    parameter int CLK_FREQ      = 50_000_000,
    parameter int BAUD          = 115_200,
    parameter int PERIOD_CYCLES = 50_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] total,
    input  logic [31:0] correct,
    input  logic        report_req,
    output logic        uart_tx,
    output logic        busy,
    output logic [15:0] frames_sent
);

    localparam int BAUD_DIV = CLK_FREQ / BAUD;
    localparam int CNT_W    = $clog2(BAUD_DIV);
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);
    localparam bit PERIOD_EN = (PERIOD_CYCLES > 0);
    localparam logic [31:0] PERIOD_LAST = PERIOD_EN ? 32'(PERIOD_CYCLES - 1) : 32'd0;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        DATA,
        STOP,
        DONE
    } state_t;

    function automatic logic [7:0] checksum(input logic [31:0] t, input logic [31:0] c);
        return t[31:24] ^ t[23:16] ^ t[15:8] ^ t[7:0] ^
               c[31:24] ^ c[23:16] ^ c[15:8] ^ c[7:0];
    endfunction

    function automatic logic [7:0] frame_byte(input logic [3:0]  idx,
                                              input logic [31:0] t,
                                              input logic [31:0] c,
                                              input logic [7:0]  chk);
        case (idx)
            4'd0:    return 8'hA5;
            4'd1:    return t[31:24];
            4'd2:    return t[23:16];
            4'd3:    return t[15:8];
            4'd4:    return t[7:0];
            4'd5:    return c[31:24];
            4'd6:    return c[23:16];
            4'd7:    return c[15:8];
            4'd8:    return c[7:0];
            default: return chk;
        endcase
    endfunction

    state_t           state, state_next;
    logic [CNT_W-1:0] baud_cnt, baud_next;
    logic [2:0]       bit_idx, bit_next;
    logic [3:0]       byte_idx, byte_next;
    logic             tx, tx_next;
    logic             pending, pending_next;
    logic [15:0]      frames, frames_next;
    logic [31:0]      timer;
    logic             tick, trigger, baud_done;
    logic             snap_take, load_byte;
    logic [3:0]       load_idx;
    logic [31:0]      snap_total, snap_correct;
    logic [7:0]       snap_chk, cur_byte;

    // Free-running period timer, independent of the transmitter
    assign tick    = PERIOD_EN && (timer == PERIOD_LAST);
    assign trigger = report_req | tick;

    always_ff @(posedge clk) begin
        if (rst) begin
            timer <= 32'd0;
        end else if (PERIOD_EN) begin
            timer <= tick ? 32'd0 : timer + 32'd1;
        end
    end

    assign baud_done = (baud_cnt == BAUD_LAST);

    always_comb begin
        state_next   = state;
        baud_next    = baud_cnt;
        bit_next     = bit_idx;
        byte_next    = byte_idx;
        tx_next      = tx;
        pending_next = pending;
        frames_next  = frames;
        snap_take    = 1'b0;
        load_byte    = 1'b0;
        load_idx     = byte_idx;

        if (trigger && (state == LOAD || state == START || state == DATA || state == STOP)) begin
            pending_next = 1'b1;
        end

        case (state)
            IDLE: begin
                tx_next = 1'b1;
                if (trigger) begin
                    snap_take  = 1'b1;
                    byte_next  = 4'd0;
                    state_next = LOAD;
                end
            end
            LOAD: begin
                load_byte  = 1'b1;
                baud_next  = '0;
                tx_next    = 1'b0;
                state_next = START;
            end
            START: begin
                if (baud_done) begin
                    baud_next  = '0;
                    bit_next   = 3'd0;
                    tx_next    = cur_byte[0];
                    state_next = DATA;
                end else begin
                    baud_next = baud_cnt + 1'b1;
                end
            end
            DATA: begin
                if (baud_done) begin
                    baud_next = '0;
                    if (bit_idx == 3'd7) begin
                        tx_next    = 1'b1;
                        state_next = STOP;
                    end else begin
                        bit_next = bit_idx + 3'd1;
                        tx_next  = cur_byte[bit_idx + 3'd1];
                    end
                end else begin
                    baud_next = baud_cnt + 1'b1;
                end
            end
            STOP: begin
                if (baud_done) begin
                    baud_next = '0;
                    if (byte_idx != 4'd9) begin
                        // Next byte's start bit follows the stop bit with no gap
                        byte_next  = byte_idx + 4'd1;
                        load_byte  = 1'b1;
                        load_idx   = byte_idx + 4'd1;
                        tx_next    = 1'b0;
                        state_next = START;
                    end else begin
                        frames_next = frames + 16'd1;
                        tx_next     = 1'b1;
                        state_next  = DONE;
                    end
                end else begin
                    baud_next = baud_cnt + 1'b1;
                end
            end
            DONE: begin
                tx_next = 1'b1;
                // A trigger arriving now is served by the frame started here
                if (pending || trigger) begin
                    pending_next = 1'b0;
                    snap_take    = 1'b1;
                    byte_next    = 4'd0;
                    state_next   = LOAD;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                tx_next    = 1'b1;
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= 3'd0;
            byte_idx <= 4'd0;
            tx       <= 1'b1;
            pending  <= 1'b0;
            frames   <= 16'd0;
        end else begin
            state    <= state_next;
            baud_cnt <= baud_next;
            bit_idx  <= bit_next;
            byte_idx <= byte_next;
            tx       <= tx_next;
            pending  <= pending_next;
            frames   <= frames_next;
        end
    end

    always_ff @(posedge clk) begin
        if (snap_take) begin
            snap_total   <= total;
            snap_correct <= correct;
            snap_chk     <= checksum(total, correct);
        end
        if (load_byte) begin
            cur_byte <= frame_byte(load_idx, snap_total, snap_correct, snap_chk);
        end
    end

    assign uart_tx     = tx;
    assign busy        = (state != IDLE);
    assign frames_sent = frames;

endmodule

// File: tb/tb_score_uart_report.sv
// Scoreboard bench: two instances (periodic tick off / on); UART monitors decode
// the serial lines and compare each byte against hand-computed expected frames.
module tb_score_uart_report;

    localparam int B = 10;

    logic        clk = 1'b0;
    logic        rst_a, rst_b, req_a, req_b;
    logic [31:0] total_a, correct_a, total_b, correct_b;
    logic        tx_a, tx_b, busy_a, busy_b;
    logic [15:0] frames_a, frames_b;

    always #5 clk = ~clk;

    score_uart_report #(.CLK_FREQ(1000), .BAUD(100), .PERIOD_CYCLES(0)) dut_a (
        .clk(clk), .rst(rst_a), .total(total_a), .correct(correct_a),
        .report_req(req_a), .uart_tx(tx_a), .busy(busy_a), .frames_sent(frames_a));

    score_uart_report #(.CLK_FREQ(1000), .BAUD(100), .PERIOD_CYCLES(2000)) dut_b (
        .clk(clk), .rst(rst_b), .total(total_b), .correct(correct_b),
        .report_req(req_b), .uart_tx(tx_b), .busy(busy_b), .frames_sent(frames_b));

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_total = 0;
    int n_bad   = 0;
    logic [7:0] exp_q[2][$];
    int         start_q[2][$];
    int         gen[2];
    int         rel;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic logic tx_of(input int i);
        return (i == 0) ? tx_a : tx_b;
    endfunction

    task automatic push_frame(input int i, input logic [31:0] t, input logic [31:0] c,
                              input logic [7:0] chk);
        exp_q[i].push_back(8'hA5);
        for (int k = 3; k >= 0; k--) exp_q[i].push_back(t[8*k +: 8]);
        for (int k = 3; k >= 0; k--) exp_q[i].push_back(c[8*k +: 8]);
        exp_q[i].push_back(chk);
    endtask

    task automatic rx_mon(input int i);
        int bidx = 0;
        int t0, g;
        logic [7:0] d;
        logic stopb;
        forever begin
            @(negedge clk);
            if (tx_of(i) == 1'b0) begin
                t0 = cyc;
                g  = gen[i];
                repeat (B / 2) @(negedge clk);
                for (int k = 0; k < 8; k++) begin
                    repeat (B) @(negedge clk);
                    d[k] = tx_of(i);
                end
                repeat (B) @(negedge clk);
                stopb = tx_of(i);
                if (g != gen[i]) begin
                    bidx = 0;
                    continue;
                end
                if (bidx == 0) start_q[i].push_back(t0);
                check($sformatf("stop_bit_%0d", i), stopb, 1'b1);
                if (exp_q[i].size() == 0) begin
                    n_total++;
                    n_bad++;
                    $display("FAIL unexpected_byte_%0d: got 0x%0h want none", i, d);
                end else begin
                    check($sformatf("byte_%0d_idx%0d", i, bidx), d, exp_q[i].pop_front());
                end
                bidx = (bidx + 1) % 10;
            end
        end
    endtask

    initial rx_mon(0);
    initial rx_mon(1);

    task automatic pulse_a(output int trig);
        @(negedge clk);
        req_a = 1'b1;
        @(posedge clk);
        #1;
        trig  = cyc;
        req_a = 1'b0;
    endtask

    task automatic wait_until(input int c);
        do @(negedge clk); while (cyc < c);
    endtask

    task automatic wait_frames_a(input logic [15:0] target, input int limit);
        int n = 0;
        while (frames_a != target && n < limit) begin
            @(negedge clk);
            n++;
        end
        check("frames_a_reached", frames_a, target);
    endtask

    task automatic check_start(input int i, input int exp);
        int v = -1;
        if (start_q[i].size() > 0) v = start_q[i].pop_front();
        check($sformatf("frame_start_%0d", i), v, exp);
    endtask

    task automatic run_a();
        int trig, dummy;
        // idle after reset
        repeat (50) begin
            @(negedge clk);
            check("idle_tx", tx_a, 1'b1);
            check("idle_busy", busy_a, 1'b0);
            check("idle_frames", frames_a, 16'd0);
        end

        // basic frame and latency
        total_a = 32'h0000_0010; correct_a = 32'h0000_000F;
        push_frame(0, total_a, correct_a, 8'h1F);
        pulse_a(trig);
        @(negedge clk);
        check("load_busy", busy_a, 1'b1);
        check("load_tx", tx_a, 1'b1);
        @(negedge clk);
        check("start_tx_low", tx_a, 1'b0);
        wait_until(trig + 1000);
        check("last_stop_frames", frames_a, 16'd0);
        check("last_stop_tx", tx_a, 1'b1);
        check("last_stop_busy", busy_a, 1'b1);
        @(negedge clk);
        check("done_frames", frames_a, 16'd1);
        check("done_busy", busy_a, 1'b1);
        @(negedge clk);
        check("idle_busy_after", busy_a, 1'b0);
        check_start(0, trig + 1);
        check("queue_empty_t2", exp_q[0].size(), 0);

        // snapshot isolation; XOR of the eight counter bytes is 0x00 here
        total_a = 32'h1234_5678; correct_a = 32'h9ABC_DEF0;
        push_frame(0, total_a, correct_a, 8'h00);
        pulse_a(trig);
        wait_until(trig + 20);
        total_a = 32'hFFFF_FFFF; correct_a = 32'h0000_0000;
        wait_frames_a(16'd2, 1100);
        check_start(0, trig + 1);
        repeat (3) @(negedge clk);
        check("queue_empty_t3", exp_q[0].size(), 0);

        // pending/merge: second frame snapshots at its own start
        total_a = 32'h0000_0001; correct_a = 32'h0000_0002;
        push_frame(0, 32'h0000_0001, 32'h0000_0002, 8'h03);
        push_frame(0, 32'hAABB_CCDD, 32'h1122_3344, 8'h44);
        pulse_a(trig);
        wait_until(trig + 100);
        pulse_a(dummy);
        wait_until(trig + 300);
        pulse_a(dummy);
        wait_until(trig + 500);
        total_a = 32'hAABB_CCDD; correct_a = 32'h1122_3344;
        wait_until(trig + 700);
        pulse_a(dummy);
        wait_frames_a(16'd4, 2500);
        check_start(0, trig + 1);
        check_start(0, trig + 1003);
        repeat (1100) @(negedge clk);
        check("merge_frames", frames_a, 16'd4);
        check("merge_busy", busy_a, 1'b0);
        check("queue_empty_t4", exp_q[0].size(), 0);

        // reset in the middle of byte 4
        total_a = 32'h0102_0304; correct_a = 32'h0506_0708;
        exp_q[0].push_back(8'hA5);
        exp_q[0].push_back(8'h01);
        exp_q[0].push_back(8'h02);
        exp_q[0].push_back(8'h03);
        pulse_a(trig);
        wait_until(trig + 415);
        rst_a = 1'b1;
        gen[0]++;
        @(negedge clk);
        check("rst_tx", tx_a, 1'b1);
        check("rst_busy", busy_a, 1'b0);
        check("rst_frames", frames_a, 16'd0);
        rst_a = 1'b0;
        repeat (200) @(negedge clk);
        check_start(0, trig + 1);
        check("queue_empty_abort", exp_q[0].size(), 0);
        check("abort_frames", frames_a, 16'd0);

        total_a = 32'hDEAD_BEEF; correct_a = 32'h00C0_FFEE;
        push_frame(0, total_a, correct_a, 8'hF3);
        pulse_a(trig);
        wait_frames_a(16'd1, 1100);
        check_start(0, trig + 1);
        repeat (5) @(negedge clk);
        check("queue_empty_t6", exp_q[0].size(), 0);
        check("post_rst_busy", busy_a, 1'b0);
    endtask

    task automatic run_b();
        for (int k = 0; k < 5; k++) push_frame(1, 32'd5, 32'd3, 8'h06);
        // report_req in the same cycle as the second tick
        wait_until(rel + 3999);
        req_b = 1'b1;
        @(negedge clk);
        req_b = 1'b0;
        wait_until(rel + 11100);
        check("periodic_frames", frames_b, 16'd5);
        for (int k = 0; k < 5; k++) check_start(1, rel + 2001 + 2000 * k);
        check("queue_empty_b", exp_q[1].size(), 0);
        check("periodic_busy", busy_b, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        gen[0] = 0; gen[1] = 0;
        rst_a = 1'b1; rst_b = 1'b1;
        req_a = 1'b0; req_b = 1'b0;
        total_a = '0; correct_a = '0;
        total_b = 32'd5; correct_b = 32'd3;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_a = 1'b0; rst_b = 1'b0;
        rel = cyc;
        fork
            run_a();
            run_b();
        join
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
